spi_slave: RTL and testbench

- 16-bit SPI responder; the far end of the team's SPI master link (sensor/AFE side model and on-chip peripheral front end).
- Receives MSB-first frames on MOSI and returns a preloaded word on MISO in the same frame.
- All SPI inputs are asynchronous to clk and are synchronized internally; SCLK is never used as a clock.

---
 rtl/spi_pkg.sv | 12 +
 rtl/spi_sync_edge.sv | 37 +++
 rtl/spi_slave.sv | 155 +++++++++++++++
 tb/tb_spi_slave.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end.
package spi_pkg;

    localparam int SPI_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } spi_slv_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, plus a history flop
// for single-cycle rise/fall pulses on the synchronized level.
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              hist_q, hist_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        hist_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
            hist_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_slave.sv
// 16-bit SPI responder: MSB-first receive on MOSI, preloaded word returned on
// MISO in the same frame. All SPI pins are oversampled by clk.
module spi_slave
    import spi_pkg::*;
#(
    parameter int WIDTH       = SPI_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SS_n,
    input  logic             SCLK,
    input  logic             MOSI,
    output logic             MISO,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             wrt,
    output logic [WIDTH-1:0] rx_data,
    output logic             rdy,
    output logic             busy,
    output logic             frame_err,
    output spi_slv_state_t   state_dbg
);

    localparam int CNT_W  = $clog2(WIDTH) + 1;
    localparam int SETTLE = SYNC_STAGES + 1;
    localparam int SET_W  = $clog2(SETTLE + 1);

    logic ss_level, ss_rise, ss_fall;
    logic sclk_rise, sclk_fall, sclk_level_unused;
    logic mosi_level, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk(clk), .rst(rst), .din(SS_n),
        .level(ss_level), .rise(ss_rise), .fall(ss_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .din(SCLK),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .din(MOSI),
        .level(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    spi_slv_state_t   state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] tx_shadow_q, tx_shadow_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic             mosi_smp_q, mosi_smp_d;
    logic             busy_q, busy_d;
    logic             rdy_q, rdy_d;
    logic             frame_err_q, frame_err_d;
    logic             armed_q, armed_d;
    logic             settled;

    // A reset while SS_n is held low would otherwise look like a fresh select
    // once the synchronizer flushes; only accept a select after SS_n was seen
    // high on a settled synchronizer.
    assign settled = (settle_q == SET_W'(SETTLE));

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        tx_shadow_d = wrt ? tx_data : tx_shadow_q;
        rx_data_d   = rx_data_q;
        bit_cnt_d   = bit_cnt_q;
        settle_d    = settled ? settle_q : settle_q + SET_W'(1);
        mosi_smp_d  = mosi_smp_q;
        busy_d      = busy_q;
        rdy_d       = 1'b0;
        frame_err_d = 1'b0;
        armed_d     = armed_q | (settled & ss_level);

        case (state_q)
            IDLE: begin
                if (ss_fall && armed_q) begin
                    shift_d   = tx_shadow_q;
                    bit_cnt_d = '0;
                    busy_d    = 1'b1;
                    state_d   = ACTIVE;
                end
            end
            ACTIVE: begin
                if (sclk_rise) begin
                    mosi_smp_d = mosi_level;
                end
                if (ss_rise) begin
                    frame_err_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end else if (sclk_fall) begin
                    shift_d = {shift_q[WIDTH-2:0], mosi_smp_q};
                    if (bit_cnt_q != CNT_W'(WIDTH)) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                    if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
                        rx_data_d = {shift_q[WIDTH-2:0], mosi_smp_q};
                        rdy_d     = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            DONE: begin
                if (ss_rise) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            tx_shadow_q <= '0;
            rx_data_q   <= '0;
            bit_cnt_q   <= '0;
            settle_q    <= '0;
            mosi_smp_q  <= 1'b0;
            busy_q      <= 1'b0;
            rdy_q       <= 1'b0;
            frame_err_q <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            tx_shadow_q <= tx_shadow_d;
            rx_data_q   <= rx_data_d;
            bit_cnt_q   <= bit_cnt_d;
            settle_q    <= settle_d;
            mosi_smp_q  <= mosi_smp_d;
            busy_q      <= busy_d;
            rdy_q       <= rdy_d;
            frame_err_q <= frame_err_d;
            armed_q     <= armed_d;
        end
    end

    // Outside a frame the master sees the shadow MSB ahead of the first fall.
    assign MISO      = (state_q == IDLE) ? tx_shadow_q[WIDTH-1] : shift_q[WIDTH-1];
    assign rx_data   = rx_data_q;
    assign rdy       = rdy_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: master model driving SS_n/SCLK/MOSI at a
// 1:32 SCLK ratio, scoreboard on rdy, vector table plus random frames.
`timescale 1ns/1ps
module tb_spi_slave;
    import spi_pkg::*;

    localparam int W    = 16;
    localparam int SYNC = 2;
    localparam int HALF = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           SS_n = 1'b1;
    logic           SCLK = 1'b0;
    logic           MOSI = 1'b0;
    logic           wrt = 1'b0;
    logic [W-1:0]   tx_data = '0;
    logic           MISO;
    logic [W-1:0]   rx_data;
    logic           rdy;
    logic           busy;
    logic           frame_err;
    spi_slv_state_t state_dbg;

    spi_slave #(.WIDTH(W), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
        .MISO(MISO), .tx_data(tx_data), .wrt(wrt), .rx_data(rx_data),
        .rdy(rdy), .busy(busy), .frame_err(frame_err), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int rdy_cnt  = 0;
    int ferr_cnt = 0;

    // reference model state
    logic [W-1:0] exp_q[$];
    logic [W-1:0] model_shadow = '0;
    logic [W-1:0] model_rx = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // scoreboard: every rdy pulse must match the oldest completed master frame
    always @(negedge clk) begin
        if (rdy) begin
            rdy_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rdy_unexpected: got rx_data %h expected no rdy", rx_data);
            end else begin
                check("rx_on_rdy", 32'(rx_data), 32'(exp_q.pop_front()));
            end
        end
        if (frame_err) ferr_cnt++;
    end

    // driver tasks
    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_tx(input logic [W-1:0] v);
        tx_data = v;
        wrt = 1'b1;
        wait_clk(1);
        wrt = 1'b0;
        model_shadow = v;
        wait_clk(1);
    endtask

    task automatic ss_low();
        SS_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic ss_high();
        SS_n = 1'b1;
        wait_clk(HALF);
    endtask

    // one SCLK period; MISO is sampled as the master drives SCLK low
    task automatic sclk_bit(input logic mo, input logic do_wrt, input logic [W-1:0] wv,
                            output logic mi);
        MOSI = mo;
        if (do_wrt) begin
            tx_data = wv;
            wrt = 1'b1;
            wait_clk(1);
            wrt = 1'b0;
            wait_clk(HALF/2 - 1);
        end else begin
            wait_clk(HALF/2);
        end
        SCLK = 1'b1;
        wait_clk(HALF);
        SCLK = 1'b0;
        mi = MISO;
        wait_clk(HALF/2);
    endtask

    task automatic run_frame(input logic [W-1:0] mo, input int extra, output logic [W-1:0] mi);
        logic b;
        exp_q.push_back(mo);
        model_rx = mo;
        ss_low();
        for (int i = 0; i < W; i++) begin
            sclk_bit(mo[W-1-i], 1'b0, '0, b);
            mi[W-1-i] = b;
        end
        for (int i = 0; i < extra; i++) sclk_bit(1'b1, 1'b0, '0, b);
        ss_high();
    endtask

    typedef struct {
        logic [W-1:0] mo;
        logic [W-1:0] tx;
        int           extra;
        logic [W-1:0] exp_rx;
        logic [W-1:0] exp_read;
    } vec_t;

    vec_t tbl[4];

    initial begin
        #2_000_000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] rd;
        logic [W-1:0] mo;
        logic         b;
        int           r0, f0;

        tbl[0] = '{mo: 16'h1234, tx: 16'hA5C3, extra: 0, exp_rx: 16'h1234, exp_read: 16'hA5C3};
        tbl[1] = '{mo: 16'hFFFF, tx: 16'h0000, extra: 0, exp_rx: 16'hFFFF, exp_read: 16'h0000};
        tbl[2] = '{mo: 16'h0001, tx: 16'h8000, extra: 2, exp_rx: 16'h0001, exp_read: 16'h8000};
        tbl[3] = '{mo: 16'h1234, tx: 16'h7E81, extra: 1, exp_rx: 16'h1234, exp_read: 16'h7E81};

        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(8);
        check("reset_rx_data", 32'(rx_data), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_miso", 32'(MISO), 32'h0);
        check("reset_rdy", 32'(rdy), 32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_state", 32'(state_dbg), 32'(IDLE));

        // vector table: loopback, back-to-back, extra SCLK pulses in DONE
        for (int i = 0; i < 4; i++) begin
            r0 = rdy_cnt;
            write_tx(tbl[i].tx);
            run_frame(tbl[i].mo, tbl[i].extra, rd);
            check("tbl_master_read", 32'(rd), 32'(tbl[i].exp_read));
            check("tbl_rx_data", 32'(rx_data), 32'(tbl[i].exp_rx));
            check("tbl_rdy_count", 32'(rdy_cnt - r0), 32'd1);
            check("tbl_busy_idle", 32'(busy), 32'h0);
        end

        // abort after 7 falls
        r0 = rdy_cnt;
        f0 = ferr_cnt;
        ss_low();
        for (int i = 0; i < 7; i++) sclk_bit(1'b1, 1'b0, '0, b);
        ss_high();
        check("abort_frame_err", 32'(ferr_cnt - f0), 32'd1);
        check("abort_no_rdy", 32'(rdy_cnt - r0), 32'd0);
        check("abort_rx_hold", 32'(rx_data), 32'h1234);
        check("abort_busy", 32'(busy), 32'h0);
        run_frame(16'hBEEF, 0, rd);
        check("after_abort_rx", 32'(rx_data), 32'hBEEF);

        // wrt coincident with synchronized ss_fall
        write_tx(16'h0F0F);
        exp_q.push_back(16'h3C3C);
        SS_n = 1'b0;
        wait_clk(SYNC);
        check("sync_latency_busy_low", 32'(busy), 32'h0);
        tx_data = 16'h5555;
        wrt = 1'b1;
        wait_clk(1);
        wrt = 1'b0;
        check("sync_latency_busy_high", 32'(busy), 32'h1);
        wait_clk(HALF - SYNC - 1);
        mo = 16'h3C3C;
        for (int i = 0; i < W; i++) begin
            sclk_bit(mo[W-1-i], 1'b0, '0, b);
            rd[W-1-i] = b;
        end
        ss_high();
        check("simul_wrt_read_old", 32'(rd), 32'h0F0F);
        model_shadow = 16'h5555;
        run_frame(16'h00C3, 0, rd);
        check("simul_wrt_read_new", 32'(rd), 32'h5555);

        // SCLK while deselected, then reset mid-frame
        r0 = rdy_cnt;
        f0 = ferr_cnt;
        for (int i = 0; i < 5; i++) begin
            SCLK = 1'b1;
            wait_clk(HALF);
            SCLK = 1'b0;
            wait_clk(HALF);
        end
        check("desel_sclk_busy", 32'(busy), 32'h0);
        check("desel_sclk_state", 32'(state_dbg), 32'(IDLE));
        ss_low();
        for (int i = 0; i < 5; i++) sclk_bit(1'b1, 1'b0, '0, b);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        model_shadow = '0;
        model_rx = '0;
        check("midrst_rx_data", 32'(rx_data), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_miso", 32'(MISO), 32'h0);
        check("midrst_state", 32'(state_dbg), 32'(IDLE));
        for (int i = 0; i < W - 5; i++) sclk_bit(1'b0, 1'b0, '0, b);
        ss_high();
        check("midrst_no_rdy", 32'(rdy_cnt - r0), 32'd0);
        check("midrst_no_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("midrst_busy_after", 32'(busy), 32'h0);
        check("midrst_rx_after", 32'(rx_data), 32'h0);
        run_frame(16'hC001, 0, rd);
        check("post_rst_read", 32'(rd), 32'h0);
        check("post_rst_rx", 32'(rx_data), 32'hC001);

        // random frames against the model: shadow snapshot at select,
        // in-frame wrt affects only later frames, random aborts
        for (int it = 0; it < 12; it++) begin
            logic [W-1:0] exp_read;
            logic [W-1:0] wv;
            int nf, wk;
            logic abort;
            mo = 16'($urandom);
            if ($urandom_range(0, 1) == 1) write_tx(16'($urandom));
            exp_read = model_shadow;
            abort = ($urandom_range(0, 3) == 0);
            nf = abort ? $urandom_range(1, W - 1) : W;
            wk = $urandom_range(0, W);
            wv = 16'($urandom);
            r0 = rdy_cnt;
            f0 = ferr_cnt;
            if (!abort) begin
                exp_q.push_back(mo);
            end
            rd = '0;
            ss_low();
            for (int i = 0; i < nf; i++) begin
                sclk_bit(mo[W-1-i], (i == wk), wv, b);
                rd[W-1-i] = b;
                if (i == wk) model_shadow = wv;
            end
            ss_high();
            if (abort) begin
                check("rnd_abort_ferr", 32'(ferr_cnt - f0), 32'd1);
                check("rnd_abort_no_rdy", 32'(rdy_cnt - r0), 32'd0);
                check("rnd_abort_rx_hold", 32'(rx_data), 32'(model_rx));
            end else begin
                model_rx = mo;
                check("rnd_read", 32'(rd), 32'(exp_read));
                check("rnd_rdy_count", 32'(rdy_cnt - r0), 32'd1);
                check("rnd_rx", 32'(rx_data), 32'(model_rx));
            end
            check("rnd_busy", 32'(busy), 32'h0);
        end

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
